rtsnoc_port_arbiter: RTL and testbench

- Shares one RTSNoC router local port between N_REQ bridge requesters, e.g. several wishbone_slave_to_rtsnoc / rtsnoc_to_wishbone_master instances.
- TX: one-entry hold register per requester, drained to the router by a round-robin state machine.
- RX: packets from the router are steered to a requester by the packet's origin local address, into a one-entry buffer per requester.
- Sits between the bridges and the router; no header rewriting.

---
 rtl/rtsnoc_port_arbiter.sv | 157 +++++++++++++++
 tb/tb_rtsnoc_port_arbiter.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtsnoc_port_arbiter.sv
// Shares one RTSNoC router local port between N_REQ bridges: round-robin TX
// from one-entry hold registers, RX steered by origin local address.
module rtsnoc_port_arbiter #(
  parameter int unsigned N_REQ             = 2,
  parameter int unsigned WB_NOC_DATA_WIDTH = 32,
  parameter int unsigned SOC_SIZE_X        = 1,
  parameter int unsigned SOC_SIZE_Y        = 1,
  parameter logic [3*N_REQ-1:0] ORIG_MAP   = {3'd2, 3'd1},
  localparam int unsigned BUS = WB_NOC_DATA_WIDTH + 2*SOC_SIZE_X + 2*SOC_SIZE_Y + 6
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [N_REQ*BUS-1:0] req_din_i,
  input  logic [N_REQ-1:0]     req_wr_i,
  output logic [N_REQ-1:0]     req_wait_o,
  output logic [N_REQ*BUS-1:0] req_dout_o,
  output logic [N_REQ-1:0]     req_nd_o,
  input  logic [N_REQ-1:0]     req_rd_i,
  output logic [BUS-1:0]       noc_din_o,
  output logic                 noc_wr_o,
  input  logic                 noc_wait_i,
  input  logic [BUS-1:0]       noc_dout_i,
  input  logic                 noc_nd_i,
  output logic                 noc_rd_o,
  output logic                 drop_o
);

  localparam int unsigned PW     = (N_REQ > 2) ? 2 : 1;
  localparam int unsigned LO_LSB = WB_NOC_DATA_WIDTH + 3 + SOC_SIZE_X + SOC_SIZE_Y;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SENT  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [BUS-1:0]   hold_d [N_REQ];
  logic [N_REQ-1:0] hold_v;
  logic [BUS-1:0]   rx_d [N_REQ];
  logic [N_REQ-1:0] rx_v;
  logic [1:0]       state;
  logic [PW-1:0]    ptr;

  logic [PW-1:0]    rr_idx [N_REQ];
  logic             gnt_any;
  logic [PW-1:0]    gnt_idx;
  logic [PW-1:0]    gnt_next;
  logic             tx_go;

  logic [2:0]       lo_orig;
  logic             rx_hit;
  logic [PW-1:0]    rx_k;
  logic             rx_free;

  // Candidates in round-robin order, starting at the pointer.
  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++)
      rr_idx[i] = PW'((32'(ptr) + i) % N_REQ);
  end

  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!gnt_any && hold_v[rr_idx[i]]) begin
        gnt_any = 1'b1;
        gnt_idx = rr_idx[i];
      end
    end
    gnt_next = (32'(gnt_idx) == N_REQ - 1) ? '0 : gnt_idx + 1'b1;
    tx_go    = (state == S_IDLE) && gnt_any && !noc_wait_i;
  end

  always_comb begin
    lo_orig = noc_dout_i[LO_LSB +: 3];
    rx_hit  = 1'b0;
    rx_k    = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!rx_hit && ORIG_MAP[3*i +: 3] == lo_orig) begin
        rx_hit = 1'b1;
        rx_k   = PW'(i);
      end
    end
    // A same-cycle pop frees the buffer, so a new packet may land on that edge.
    rx_free = !rx_v[rx_k] || req_rd_i[rx_k];
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      hold_v <= '0;
      for (int unsigned k = 0; k < N_REQ; k++) hold_d[k] <= '0;
    end else begin
      for (int unsigned k = 0; k < N_REQ; k++) begin
        if (req_wr_i[k] && !hold_v[k]) begin
          hold_d[k] <= req_din_i[k*BUS +: BUS];
          hold_v[k] <= 1'b1;
        end else if (tx_go && gnt_idx == PW'(k)) begin
          hold_v[k] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state     <= S_IDLE;
      ptr       <= '0;
      noc_wr_o  <= 1'b0;
      noc_din_o <= '0;
    end else begin
      noc_wr_o <= 1'b0;
      case (state)
        S_IDLE: if (tx_go) begin
          noc_din_o <= hold_d[gnt_idx];
          noc_wr_o  <= 1'b1;
          ptr       <= gnt_next;
          state     <= S_SENT;
        end
        S_SENT:  state <= S_DRAIN;
        S_DRAIN: if (!noc_wait_i) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // noc_rd_o doubles as the one-cycle ignore window for a stretched nd.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rx_v     <= '0;
      noc_rd_o <= 1'b0;
      drop_o   <= 1'b0;
      for (int unsigned k = 0; k < N_REQ; k++) rx_d[k] <= '0;
    end else begin
      noc_rd_o <= 1'b0;
      drop_o   <= 1'b0;
      for (int unsigned k = 0; k < N_REQ; k++)
        if (req_rd_i[k]) rx_v[k] <= 1'b0;
      if (noc_nd_i && !noc_rd_o) begin
        if (!rx_hit) begin
          noc_rd_o <= 1'b1;
          drop_o   <= 1'b1;
        end else if (rx_free) begin
          noc_rd_o   <= 1'b1;
          rx_d[rx_k] <= noc_dout_i;
          rx_v[rx_k] <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    req_wait_o = hold_v | req_wr_i;
    req_nd_o   = rx_v;
    req_dout_o = '0;
    for (int unsigned k = 0; k < N_REQ; k++)
      req_dout_o[k*BUS +: BUS] = rx_d[k];
  end

endmodule

// File: tb/tb_rtsnoc_port_arbiter.sv
// Randomized bench for rtsnoc_port_arbiter against a set/queue-level model
// of the hold registers, round-robin grant order and per-requester RX order.
`timescale 1ns/1ps
module tb_rtsnoc_port_arbiter;
  localparam int unsigned N      = 2;
  localparam int unsigned W      = 32;
  localparam int unsigned BUS    = W + 2 + 2 + 6;
  localparam int unsigned LO_LSB = W + 3 + 1 + 1;

  logic             clk = 1'b0;
  logic             rst_i = 1'b0;
  logic [N*BUS-1:0] req_din_i = '0;
  logic [N-1:0]     req_wr_i = '0;
  logic [N-1:0]     req_wait_o;
  logic [N*BUS-1:0] req_dout_o;
  logic [N-1:0]     req_nd_o;
  logic [N-1:0]     req_rd_i = '0;
  logic [BUS-1:0]   noc_din_o;
  logic             noc_wr_o;
  logic             noc_wait_i = 1'b0;
  logic [BUS-1:0]   noc_dout_i = '0;
  logic             noc_nd_i = 1'b0;
  logic             noc_rd_o;
  logic             drop_o;

  rtsnoc_port_arbiter #(.N_REQ(N), .WB_NOC_DATA_WIDTH(W), .SOC_SIZE_X(1), .SOC_SIZE_Y(1),
                        .ORIG_MAP({3'd2, 3'd1})) dut (
    .clk_i(clk), .rst_i(rst_i), .req_din_i(req_din_i), .req_wr_i(req_wr_i),
    .req_wait_o(req_wait_o), .req_dout_o(req_dout_o), .req_nd_o(req_nd_o),
    .req_rd_i(req_rd_i), .noc_din_o(noc_din_o), .noc_wr_o(noc_wr_o),
    .noc_wait_i(noc_wait_i), .noc_dout_i(noc_dout_i), .noc_nd_i(noc_nd_i),
    .noc_rd_o(noc_rd_o), .drop_o(drop_o));

  always #5 clk = ~clk;

  int unsigned n_checks = 0, n_fail = 0;

  // Router TX side: raises wait for rwait cycles starting the cycle after a wr.
  int unsigned rwait = 2, rcnt = 0;
  logic        wr_seen = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      wr_seen = noc_wr_o;
      @(posedge clk);
      #1;
      if (!rst_i) begin
        rcnt = 0;
        noc_wait_i = 1'b0;
      end else begin
        if (wr_seen) rcnt = rwait;
        noc_wait_i = (rcnt != 0);
        if (rcnt != 0) rcnt--;
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [BUS-1:0] mk(input logic [2:0] lo, input logic [2:0] ld,
                                        input logic [31:0] data);
    logic [3:0] xy;
    xy = 4'($urandom);
    return {xy[3], xy[2], lo, xy[1], xy[0], ld, data};
  endfunction

  function automatic int map_k(input logic [BUS-1:0] p);
    logic [2:0] lo;
    lo = p[LO_LSB +: 3];
    if (lo == 3'd1) return 0;
    if (lo == 3'd2) return 1;
    return -1;
  endfunction

  // ---------------- TX model ----------------
  logic [N-1:0]   m_pend, m_wr_prev;
  logic [BUS-1:0] m_data [N];
  logic [BUS-1:0] m_din_prev [N];
  int unsigned    m_ptr, cyc, last_wr;
  logic [BUS-1:0] tx_log [$];

  task automatic model_reset();
    m_pend = '0; m_wr_prev = '0; m_ptr = 0; cyc = 3; last_wr = 0;
    tx_log.delete();
  endtask

  task automatic tx_tick(input logic [N-1:0] wr, input logic [BUS-1:0] d0, input logic [BUS-1:0] d1);
    logic [N-1:0] old;
    int unsigned  g;
    bit           found;
    @(negedge clk);
    cyc++;
    old = m_pend;
    if (noc_wr_o === 1'b1) begin
      found = 0; g = 0;
      for (int unsigned i = 0; i < N; i++)
        if (!found && m_pend[(m_ptr + i) % N]) begin found = 1; g = (m_ptr + i) % N; end
      n_checks++;
      if (!found) begin
        n_fail++; $display("FAIL tx_grant: noc_wr_o=1 but no packet is held");
      end else if (noc_din_o !== m_data[g]) begin
        n_fail++; $display("FAIL tx_pkt: got %h, expected %h (req %0d)", noc_din_o, m_data[g], g);
      end
      n_checks++;
      if (cyc - last_wr < 3) begin
        n_fail++; $display("FAIL tx_spacing: %0d cycles between writes, need >= 3", cyc - last_wr);
      end
      last_wr = cyc;
      tx_log.push_back(noc_din_o);
      if (found) begin m_pend[g] = 1'b0; m_ptr = (g + 1) % N; end
    end
    for (int unsigned k = 0; k < N; k++)
      if (m_wr_prev[k] && !old[k]) begin m_pend[k] = 1'b1; m_data[k] = m_din_prev[k]; end
    req_wr_i = wr; req_din_i = {d1, d0};
    m_wr_prev = wr; m_din_prev[0] = d0; m_din_prev[1] = d1;
    #1;
    n_checks++;
    if (req_wait_o !== (m_pend | wr)) begin
      n_fail++; $display("FAIL tx_wait: got %b, expected %b", req_wait_o, m_pend | wr);
    end
  endtask

  // ---------------- RX model ----------------
  logic [BUS-1:0] rq [$], exp0 [$], exp1 [$];
  int unsigned    rd_cnt, drop_cnt;
  logic           prev_rd = 1'b0;

  task automatic rx_push(input logic [BUS-1:0] p);
    rq.push_back(p);
    if (map_k(p) == 0) exp0.push_back(p);
    else if (map_k(p) == 1) exp1.push_back(p);
  endtask

  task automatic rx_tick(input logic [N-1:0] pop_en);
    logic [N-1:0]   rd;
    logic [BUS-1:0] got, want;
    bit             have;
    @(negedge clk);
    if (noc_rd_o === 1'b1) begin
      rd_cnt++;
      n_checks++;
      if (rq.size() == 0) begin
        n_fail++; $display("FAIL rx_rd: noc_rd_o with no packet offered");
      end else begin
        if (drop_o !== (map_k(rq[0]) < 0)) begin
          n_fail++; $display("FAIL rx_drop: drop_o=%b for local_orig %0d", drop_o, rq[0][LO_LSB +: 3]);
        end
        void'(rq.pop_front());
      end
      n_checks++;
      if (prev_rd === 1'b1) begin
        n_fail++; $display("FAIL rx_rd_twice: noc_rd_o=1 on consecutive cycles");
      end
    end else begin
      n_checks++;
      if (drop_o !== 1'b0) begin n_fail++; $display("FAIL rx_drop_idle: drop_o=%b, expected 0", drop_o); end
    end
    if (drop_o === 1'b1) drop_cnt++;
    prev_rd = noc_rd_o;
    noc_nd_i = (rq.size() != 0);
    if (rq.size() != 0) noc_dout_i = rq[0];
    rd = '0;
    for (int k = 0; k < int'(N); k++) begin
      if (req_nd_o[k] && pop_en[k]) begin
        rd[k] = 1'b1;
        got = req_dout_o[k*BUS +: BUS];
        have = (k == 0) ? (exp0.size() != 0) : (exp1.size() != 0);
        n_checks++;
        if (!have) begin
          n_fail++; $display("FAIL rx_unexpected: req %0d got %h, nothing expected", k, got);
        end else begin
          want = (k == 0) ? exp0.pop_front() : exp1.pop_front();
          if (got !== want) begin
            n_fail++; $display("FAIL rx_data: req %0d got %h, expected %h", k, got, want);
          end
        end
      end
    end
    req_rd_i = rd;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_i = 1'b0;
    @(negedge clk); #1;
    n_checks++;
    if ({noc_wr_o, noc_rd_o, drop_o, req_nd_o, req_wait_o} !== '0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b, expected 0", {noc_wr_o, noc_rd_o, drop_o, req_nd_o, req_wait_o});
    end
    n_checks++;
    if (noc_din_o !== '0 || req_dout_o !== '0) begin
      n_fail++; $display("FAIL reset_data: noc_din_o=%h req_dout_o=%h, expected 0", noc_din_o, req_dout_o);
    end
    @(negedge clk);
    rst_i = 1'b1;
    model_reset();
  endtask

  task automatic test_fairness(input int first);
    logic [BUS-1:0] d0, d1;
    rwait = 2;
    tx_log.delete();
    d0 = mk(3'd1, 3'd1, $urandom);
    d1 = mk(3'd2, 3'd1, $urandom);
    tx_tick(2'b11, d0, d1);
    repeat (14) tx_tick('0, '0, '0);
    n_checks++;
    if (tx_log.size() != 2) begin
      n_fail++; $display("FAIL fair_count: %0d packets sent, expected 2", tx_log.size());
    end else begin
      n_checks++;
      if (tx_log[0] !== (first == 0 ? d0 : d1) || tx_log[1] !== (first == 0 ? d1 : d0)) begin
        n_fail++; $display("FAIL fair_order: got %h,%h expected req%0d first", tx_log[0], tx_log[1], first);
      end
    end
  endtask

  task automatic test_single_tx();
    logic [BUS-1:0] d;
    rwait = 2;
    d = mk(3'd1, 3'd1, 32'hAABBCCDD);
    tx_tick(2'b01, d, '0);
    n_checks++;
    if (req_wait_o[0] !== 1'b1) begin n_fail++; $display("FAIL single_wait: got %b, expected 1", req_wait_o[0]); end
    tx_tick('0, '0, '0);
    n_checks++;
    if (noc_wr_o !== 1'b0 || req_wait_o[0] !== 1'b1) begin
      n_fail++; $display("FAIL single_hold: wr=%b wait=%b, expected 0/1", noc_wr_o, req_wait_o[0]);
    end
    tx_tick('0, '0, '0);
    n_checks++;
    if (noc_wr_o !== 1'b1 || noc_din_o !== d) begin
      n_fail++; $display("FAIL single_send: wr=%b din=%h, expected 1/%h", noc_wr_o, noc_din_o, d);
    end
    tx_tick('0, '0, '0);
    n_checks++;
    if (noc_wr_o !== 1'b0 || req_wait_o[0] !== 1'b0 || noc_din_o !== d) begin
      n_fail++; $display("FAIL single_after: wr=%b wait=%b din=%h, expected 0/0/%h", noc_wr_o, req_wait_o[0], noc_din_o, d);
    end
    repeat (6) tx_tick('0, '0, '0);
  endtask

  task automatic test_rx_steering();
    logic [BUS-1:0] p0, p1;
    rd_cnt = 0; drop_cnt = 0;
    p0 = mk(3'd1, 3'd0, 32'hEEEEFFFF);
    p1 = mk(3'd2, 3'd0, 32'hFFFFEEEE);
    rx_push(p0); rx_push(p1);
    repeat (8) rx_tick('0);
    n_checks++;
    if (rd_cnt != 2 || req_nd_o !== 2'b11) begin
      n_fail++; $display("FAIL steer_accept: rd pulses=%0d nd=%b, expected 2/11", rd_cnt, req_nd_o);
    end
    n_checks++;
    if (req_dout_o[0 +: BUS] !== p0 || req_dout_o[BUS +: BUS] !== p1) begin
      n_fail++; $display("FAIL steer_data: got %h, expected %h", req_dout_o, {p1, p0});
    end
    rx_tick(2'b11);
    repeat (2) rx_tick('0);
    n_checks++;
    if (req_nd_o !== 2'b00) begin n_fail++; $display("FAIL steer_pop: nd=%b, expected 00", req_nd_o); end
  endtask

  task automatic test_rx_backpressure();
    logic [BUS-1:0] a, b;
    rd_cnt = 0;
    a = mk(3'd1, 3'd2, $urandom);
    b = mk(3'd1, 3'd2, $urandom);
    rx_push(a); rx_push(b);
    repeat (8) rx_tick('0);
    n_checks++;
    if (rd_cnt != 1 || noc_rd_o !== 1'b0 || req_nd_o[0] !== 1'b1 || req_dout_o[0 +: BUS] !== a) begin
      n_fail++; $display("FAIL bp_hold: rd pulses=%0d rd=%b nd0=%b data=%h, expected 1/0/1/%h",
                         rd_cnt, noc_rd_o, req_nd_o[0], req_dout_o[0 +: BUS], a);
    end
    rx_tick(2'b01);
    rx_tick('0);
    n_checks++;
    if (noc_rd_o !== 1'b1 || req_nd_o[0] !== 1'b1 || req_dout_o[0 +: BUS] !== b) begin
      n_fail++; $display("FAIL bp_release: rd=%b nd0=%b data=%h, expected 1/1/%h",
                         noc_rd_o, req_nd_o[0], req_dout_o[0 +: BUS], b);
    end
    rx_tick(2'b01);
    rx_tick('0);
    n_checks++;
    if (rd_cnt != 2 || req_nd_o !== 2'b00) begin
      n_fail++; $display("FAIL bp_end: rd pulses=%0d nd=%b, expected 2/00", rd_cnt, req_nd_o);
    end
  endtask

  task automatic test_unmapped();
    rd_cnt = 0; drop_cnt = 0;
    rx_push(mk(3'd5, 3'd1, $urandom));
    repeat (4) rx_tick('0);
    n_checks++;
    if (rd_cnt != 1 || drop_cnt != 1 || req_nd_o !== 2'b00) begin
      n_fail++; $display("FAIL unmapped: rd=%0d drop=%0d nd=%b, expected 1/1/00", rd_cnt, drop_cnt, req_nd_o);
    end
  endtask

  task automatic random_tx();
    logic [N-1:0] wr;
    for (int unsigned ph = 0; ph < 4; ph++) begin
      rwait = ph;
      repeat (60) begin
        wr = N'($urandom);
        tx_tick(wr, mk(3'($urandom), 3'($urandom), $urandom), mk(3'($urandom), 3'($urandom), $urandom));
      end
    end
    repeat (40) tx_tick('0, '0, '0);
    n_checks++;
    if (m_pend !== '0) begin n_fail++; $display("FAIL tx_drain: still held %b after drain window", m_pend); end
  endtask

  task automatic random_rx();
    int unsigned n_unmapped = 0;
    logic [2:0]  lo;
    drop_cnt = 0;
    for (int i = 0; i < 80; i++) begin
      lo = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'($urandom_range(1, 2));
      if (lo != 3'd1 && lo != 3'd2) n_unmapped++;
      rx_push(mk(lo, 3'($urandom), $urandom));
    end
    for (int c = 0; c < 3000 && (rq.size() != 0 || exp0.size() != 0 || exp1.size() != 0); c++)
      rx_tick(N'($urandom));
    repeat (3) rx_tick('0);
    n_checks++;
    if (rq.size() != 0 || exp0.size() != 0 || exp1.size() != 0) begin
      n_fail++; $display("FAIL rx_timeout: %0d/%0d/%0d packets outstanding", rq.size(), exp0.size(), exp1.size());
    end
    n_checks++;
    if (drop_cnt != n_unmapped) begin
      n_fail++; $display("FAIL rx_drops: got %0d, expected %0d", drop_cnt, n_unmapped);
    end
  endtask

  task automatic test_concurrent();
    fork
      random_tx();
      random_rx();
    join
  endtask

  task automatic test_reset_mid();
    logic [BUS-1:0] d;
    rwait = 20;
    tx_tick(2'b01, mk(3'd1, 3'd1, $urandom), '0);
    repeat (4) tx_tick('0, '0, '0);
    tx_tick(2'b11, mk(3'd1, 3'd1, $urandom), mk(3'd2, 3'd1, $urandom));
    tx_tick('0, '0, '0);
    n_checks++;
    if (req_wait_o !== 2'b11 || noc_wait_i !== 1'b1) begin
      n_fail++; $display("FAIL mid_setup: wait=%b router_wait=%b, expected 11/1", req_wait_o, noc_wait_i);
    end
    @(posedge clk); #2;
    rst_i = 1'b0;
    #1;
    n_checks++;
    if ({noc_wr_o, noc_rd_o, drop_o, req_nd_o, req_wait_o} !== '0 || noc_din_o !== '0) begin
      n_fail++; $display("FAIL mid_reset: ctrl=%b din=%h, expected 0", {noc_wr_o, noc_rd_o, drop_o, req_nd_o, req_wait_o}, noc_din_o);
    end
    repeat (2) @(negedge clk);
    rst_i = 1'b1;
    model_reset();
    rwait = 2;
    d = mk(3'd2, 3'd3, $urandom);
    tx_tick(2'b10, '0, d);
    tx_tick('0, '0, '0);
    tx_tick('0, '0, '0);
    n_checks++;
    if (noc_wr_o !== 1'b1 || noc_din_o !== d) begin
      n_fail++; $display("FAIL mid_resume: wr=%b din=%h, expected 1/%h", noc_wr_o, noc_din_o, d);
    end
    repeat (6) tx_tick('0, '0, '0);
  endtask

  initial begin
    model_reset();
    rd_cnt = 0; drop_cnt = 0;
    test_reset();
    test_fairness(0);
    test_single_tx();
    test_fairness(1);
    test_rx_steering();
    test_rx_backpressure();
    test_unmapped();
    test_concurrent();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
